// File: rtl/uart_rx_if.sv
// Parallel-side bus of the UART receiver: received byte, strobes, busy
// flag and the FSM state for observation.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic [1:0] state;

  // Handshake: rx_valid is a one-cycle strobe with no ready/back-pressure;
  // rx_data is new in the cycle rx_valid is high and holds until the next
  // good byte. frame_err is a one-cycle strobe, never high with rx_valid.
  modport master (output rx_data, output rx_valid, output rx_busy,
                  output frame_err, output state);
  modport slave  (input rx_data, input rx_valid, input rx_busy,
                  input frame_err, input state);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line. Start detection is
// edge-based, each bit is sampled once at mid-bit, and a bad stop bit
// raises frame_err instead of delivering the byte.
module uart_rx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int BAUD_TICK = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_TICK = BAUD_TICK / 2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_TICK - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_TICK - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  logic        sync_ff;
  logic        rx_s;
  logic        rx_prev;
  logic        fall;
  logic [15:0] cnt;
  logic [2:0]  bit_index;
  logic [7:0]  shift;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        busy_q;
  logic        ferr_q;

  // Two-flop synchronizer plus one delay stage for edge detection; all
  // reset to the idle-high level so reset release cannot fake a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_ff <= rx;
      rx_s    <= sync_ff;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  // Frame FSM: half a bit to the start-bit centre, then one full bit per
  // sample; strobes are registered and cleared every cycle by default.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      bit_index <= 3'd0;
      shift     <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state)
        IDLE: begin
          cnt       <= 16'd0;
          bit_index <= 3'd0;
          if (fall) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= 16'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              // Line back high at the start-bit centre: a glitch, not a frame.
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BAUD_LAST) begin
            cnt              <= 16'd0;
            shift[bit_index] <= rx_s;
            if (bit_index == 3'd7) begin
              state <= STOP;
            end else begin
              bit_index <= bit_index + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == BAUD_LAST) begin
            cnt <= 16'd0;
            if (rx_s) begin
              data_q  <= shift;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = ferr_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_TICK=10, HALF_TICK=5.
module tb_uart_rx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CLK  = 10;

  logic clk;
  logic reset;
  logic rx;

  uart_rx_if bus ();

  uart_rx #(.CLOCK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks;
  int n_errs;
  int valid_cnt;
  int ferr_cnt;
  int both_cnt;
  int busy_cnt;
  int prev_valid_cyc;
  int last_valid_cyc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Monitor: sampled on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (bus.rx_busy) busy_cnt++;
    if (bus.rx_valid && bus.frame_err) both_cnt++;
    if (bus.frame_err) ferr_cnt++;
    if (bus.rx_valid) begin
      valid_cnt++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cycle;
      if (exp_q.size() == 0) check("unexpected_valid", 32'(bus.rx_data), 32'hxx);
      else check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    idle(BIT_CLK);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  // ---------------- stimulus ----------------
  int v0, f0, b0;

  initial begin
    rx    = 1'b1;
    reset = 1'b0;
    cycle = 0;
    n_checks = 0;
    n_errs = 0;
    valid_cnt = 0;
    ferr_cnt = 0;
    both_cnt = 0;
    busy_cnt = 0;
    prev_valid_cyc = 0;
    last_valid_cyc = 0;
    idle(4);
    check("rst_data",  32'(bus.rx_data),   32'h00);
    check("rst_valid", 32'(bus.rx_valid),  32'h0);
    check("rst_busy",  32'(bus.rx_busy),   32'h0);
    check("rst_ferr",  32'(bus.frame_err), 32'h0);
    check("rst_state", 32'(bus.state),     32'h0);
    reset = 1'b1;
    idle(5);

    // Single frame 0xA5.
    v0 = valid_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1);
    idle(20);
    check("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("a5_ferr_cnt",  32'(ferr_cnt), 32'd0);
    check("a5_busy",      32'(bus.rx_busy), 32'h0);
    check("a5_data",      32'(bus.rx_data), 32'hA5);

    // 3-cycle glitch while idle: false start.
    v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cnt;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    check("glitch_ferr",  32'(ferr_cnt - f0), 32'd0);
    check("glitch_busy_le6", 32'((busy_cnt - b0) <= 6), 32'd1);
    check("glitch_busy_seen", 32'((busy_cnt - b0) >= 1), 32'd1);
    check("glitch_busy_end", 32'(bus.rx_busy), 32'h0);

    // 0x3C with a low stop bit, then line held low (break).
    v0 = valid_cnt; f0 = ferr_cnt;
    send_byte(8'h3C, 1'b0);
    idle(50);
    check("ferr_cnt",   32'(ferr_cnt - f0), 32'd1);
    check("ferr_valid", 32'(valid_cnt - v0), 32'd0);
    check("ferr_data",  32'(bus.rx_data), 32'hA5);
    check("break_busy", 32'(bus.rx_busy), 32'h0);
    check("break_state", 32'(bus.state), 32'h0);
    rx = 1'b1;
    idle(20);
    check("break_release_ferr", 32'(ferr_cnt - f0), 32'd1);

    // Back-to-back 0x00, 0xFF with no idle gap.
    v0 = valid_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(20);
    check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
    check("b2b_gap", 32'(last_valid_cyc - prev_valid_cyc), 32'd100);
    check("b2b_data", 32'(bus.rx_data), 32'hFF);

    // Reset in the middle of data bit 4 of 0x5A, then 0xC3.
    v0 = valid_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
    rx = 1'b1;            // bit 4 of 0x5A
    idle(5);
    reset = 1'b0;
    idle(2);
    check("mid_rst_data",  32'(bus.rx_data),   32'h00);
    check("mid_rst_valid", 32'(bus.rx_valid),  32'h0);
    check("mid_rst_busy",  32'(bus.rx_busy),   32'h0);
    check("mid_rst_ferr",  32'(bus.frame_err), 32'h0);
    check("mid_rst_state", 32'(bus.state),     32'h0);
    idle(3);
    reset = 1'b1;
    idle(20);
    check("post_rst_valid", 32'(valid_cnt - v0), 32'd0);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    idle(20);
    check("c3_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("c3_data", 32'(bus.rx_data), 32'hC3);

    // Final report.
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("valid_and_ferr", 32'(both_cnt), 32'd0);
    check("total_ferr", 32'(ferr_cnt), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
